elm_hidden_neuron: RTL and testbench

Hidden-layer neuron of the ELM datapath, sitting directly downstream of a per-neuron weight memory. It accepts the input feature stream one sample per cycle and drives `ren`/`raddr` to its weight memory. It multiplies each sample by the returned weight in signed fixed point, accumulates with saturation, adds the bias, and emits one activation per input vector. Consecutive vectors stream back-to-back without stalls.

---
 rtl/elm_pkg.sv | 10 +
 rtl/elm_sat_add.sv | 23 ++
 rtl/elm_hidden_neuron.sv | 112 +++++++++++
 tb/tb_elm_hidden_neuron.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared defaults for the ELM datapath: operand width, fractional bits and saturation limits.
package elm_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/elm_sat_add.sv
// Combinational signed adder that clamps to the WIDTH-bit range instead of wrapping.
module elm_sat_add
  import elm_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] s;

  assign s = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // The two top bits of the widened sum disagree exactly when the narrow result overflowed.
  always_comb begin
    y = s[WIDTH-1:0];
    if (s[WIDTH] != s[WIDTH-1])
      y = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/elm_hidden_neuron.sv
// ELM hidden neuron: weight fetch, saturating MAC, bias add, optional ReLU (ELM_RELU_EN); 4 cycles last sample to outvalid.
// No backpressure: one sample per cycle when myinputValid is high; gaps just stall the empty stages.
module elm_hidden_neuron
  import elm_pkg::*;
#(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = DATA_WIDTH,
  parameter int fracBits     = FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dataWidth-1:0]    myinput,
  input  logic                    myinputValid,
  input  logic [dataWidth-1:0]    bias,
  output logic                    ren,
  output logic [addressWidth:0]   raddr,
  input  logic [dataWidth-1:0]    wout,
  output logic [dataWidth-1:0]    out,
  output logic                    outvalid
);

  localparam logic [addressWidth:0] WLAST = (addressWidth+1)'(numWeight - 1);
  localparam logic [dataWidth-1:0] DMAX = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] DMIN = {1'b1, {(dataWidth-1){1'b0}}};
  localparam logic signed [2*dataWidth-1:0] PMAX = {{(dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [2*dataWidth-1:0] PMIN = {{(dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

  logic [addressWidth:0]      wcnt;
  logic [dataWidth-1:0]       in_r, mul_r, sum, mul_next, acc_sum, r, act;
  logic                       v1, first1, last1;
  logic                       v2, first2, last2;
  logic                       fin;
  logic [2*dataWidth-1:0]     prod;
  logic signed [2*dataWidth-1:0] prod_sh;

  assign ren   = myinputValid;
  assign raddr = wcnt;

  // Sign-extended operands so the low 2*dataWidth bits of the product are the signed product.
  assign prod    = {{dataWidth{in_r[dataWidth-1]}}, in_r} * {{dataWidth{wout[dataWidth-1]}}, wout};
  assign prod_sh = $signed(prod) >>> fracBits;

  always_comb begin
    mul_next = prod_sh[dataWidth-1:0];
    if (prod_sh > PMAX)
      mul_next = DMAX;
    else if (prod_sh < PMIN)
      mul_next = DMIN;
  end

  elm_sat_add #(.WIDTH(dataWidth)) u_acc (
    .a (sum),
    .b (mul_r),
    .y (acc_sum)
  );

  elm_sat_add #(.WIDTH(dataWidth)) u_bias (
    .a (sum),
    .b (bias),
    .y (r)
  );

`ifdef ELM_RELU_EN
  assign act = r[dataWidth-1] ? '0 : r;
`else
  assign act = r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt     <= '0;
      in_r     <= '0;
      v1       <= 1'b0;
      first1   <= 1'b0;
      last1    <= 1'b0;
      mul_r    <= '0;
      v2       <= 1'b0;
      first2   <= 1'b0;
      last2    <= 1'b0;
      sum      <= '0;
      fin      <= 1'b0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      v1 <= myinputValid;
      if (myinputValid) begin
        in_r   <= myinput;
        first1 <= (wcnt == '0);
        last1  <= (wcnt == WLAST);
        wcnt   <= (wcnt == WLAST) ? '0 : wcnt + 1'b1;
      end

      v2 <= v1;
      if (v1) begin
        mul_r  <= mul_next;
        first2 <= first1;
        last2  <= last1;
      end

      // A new vector's first product may overwrite sum while fin still reads the old value.
      if (v2)
        sum <= first2 ? mul_r : acc_sum;
      fin <= v2 & last2;

      outvalid <= fin;
      if (fin)
        out <= act;
    end
  end

endmodule

// File: tb/tb_elm_hidden_neuron.sv
// Directed bench for elm_hidden_neuron with numWeight=4 and a registered 1-cycle weight memory model.
module tb_elm_hidden_neuron;
  import elm_pkg::*;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] myinput = '0;
  logic        myinputValid = 1'b0;
  logic [15:0] bias = '0;
  logic        ren;
  logic [10:0] raddr;
  logic [15:0] wout = '0;
  logic [15:0] out;
  logic        outvalid;

  logic [15:0] wmem [4];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] ovq [$];
  int          ovc [$];

`ifdef ELM_RELU_EN
  localparam logic [15:0] EXP_NEG    = 16'h0000;
  localparam logic [15:0] EXP_NEGSAT = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG    = 16'hFC00;
  localparam logic [15:0] EXP_NEGSAT = SAT_MIN;
`endif

  elm_hidden_neuron #(
    .numWeight    (NW),
    .addressWidth (10),
    .dataWidth    (16),
    .fracBits     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .myinput      (myinput),
    .myinputValid (myinputValid),
    .bias         (bias),
    .ren          (ren),
    .raddr        (raddr),
    .wout         (wout),
    .out          (out),
    .outvalid     (outvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ren) wout <= wmem[raddr[1:0]];
  always @(negedge clk) if (outvalid) begin
    ovq.push_back(out);
    ovc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
    wmem[0] = w0; wmem[1] = w1; wmem[2] = w2; wmem[3] = w3;
  endtask

  // Drives one vector of identical samples; lc is the cycle of the last accepted sample.
  task automatic send(input logic [15:0] x, input int gap, output int lc);
    lc = 0;
    for (int i = 0; i < NW; i++) begin
      @(posedge clk); #1;
      myinputValid = 1'b1;
      myinput      = x;
      @(negedge clk);
      check("raddr", 32'(raddr), 32'(i));
      check("ren", 32'(ren), 32'd1);
      lc = cyc;
      if (gap > 0 && i < NW - 1) begin
        @(posedge clk); #1;
        myinputValid = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
    end
  endtask

  task automatic stop_in();
    @(posedge clk); #1;
    myinputValid = 1'b0;
  endtask

  task automatic collect(input string tag, input int n);
    int k = 0;
    while (ovq.size() < n && k < 30) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    check(tag, 32'(ovq.size()), 32'(n));
  endtask

  task automatic pop(input string tag, input logic [15:0] e, input int lc);
    logic [15:0] v = 'x;
    int          c = -100;
    if (ovq.size() > 0) begin
      v = ovq.pop_front();
      c = ovc.pop_front();
    end
    check({tag, "_val"}, 32'(v), 32'(e));
    check({tag, "_lat"}, 32'(c - lc), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lc1, lc2;
    set_w(16'h0100, 16'h0200, 16'hFF00, 16'h0080);

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_outvalid", 32'(outvalid), 32'h0);
    check("rst_raddr", 32'(raddr), 32'h0);
    check("rst_ren", 32'(ren), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic vector: 1 + 2 - 1 + 0.5
    send(16'h0100, 0, lc1);
    stop_in();
    collect("basic_pulses", 1);
    pop("basic", 16'h0280, lc1);
    check("basic_hold", 32'(out), 32'h0280);
    check("basic_ovlow", 32'(outvalid), 32'h0);

    // Back-to-back vectors
    send(16'h0100, 0, lc1);
    send(16'h0200, 0, lc2);
    stop_in();
    collect("b2b_pulses", 2);
    pop("b2b_a", 16'h0280, lc1);
    pop("b2b_b", 16'h0500, lc2);
    check("b2b_spacing", 32'(lc2 - lc1), 32'd4);

    // Positive product and accumulator saturation
    set_w(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    send(16'h7F00, 0, lc1);
    stop_in();
    collect("psat_pulses", 1);
    pop("psat", SAT_MAX, lc1);

    // Negative saturation
    set_w(16'h8100, 16'h8100, 16'h8100, 16'h8100);
    send(16'h7F00, 0, lc1);
    stop_in();
    collect("nsat_pulses", 1);
    pop("nsat", EXP_NEGSAT, lc1);

    // Bias add saturation: 2.5 + 127.0
    set_w(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    bias = 16'h7F00;
    send(16'h0100, 0, lc1);
    stop_in();
    collect("bsat_pulses", 1);
    pop("bsat", 16'h7FFF, lc1);
    bias = 16'h0000;

    // Negative result, ReLU-dependent
    set_w(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
    send(16'h0100, 0, lc1);
    stop_in();
    collect("neg_pulses", 1);
    pop("neg", EXP_NEG, lc1);

    // Input gaps of 3 cycles
    set_w(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    send(16'h0100, 3, lc1);
    stop_in();
    collect("gap_pulses", 1);
    pop("gap", 16'h0280, lc1);

    // Reset mid-vector, with valid asserted while reset is high
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      myinputValid = 1'b1;
      myinput      = 16'h0100;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_raddr", 32'(raddr), 32'h0);
    @(posedge clk); #1;
    myinputValid = 1'b0;
    rst = 1'b0;
    send(16'h0100, 0, lc1);
    stop_in();
    collect("rst_pulses", 1);
    pop("rst_vec", 16'h0280, lc1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
